ddr_ctr_rd_check: RTL and testbench
===================================

Name: ddr_ctr_rd_check

Overview:
Read-back checker sitting directly downstream of the DDR write test stage. On `start` (driven by the writer once its write has completed) it issues one AXI4 read burst to the same DDR address. It compares every returned beat against the known write pattern and reports pass/fail/timeout. Purpose: board-level DDR controller bring-up without a CPU.

Parameters:
ADDR, 32'h0000_F000, read burst start address (must match writer address)
BURST_LEN, 1, beats per burst, legal 1..256
PATTERN, 128'h00000000_00000000_12345678_87654321, expected data of beat 0
TIMEOUT_CYC, 1024, max cycles waiting on any single handshake (AR or R beat), >=2

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse, begin check; ignored unless idle
araddr  out  32  constant ADDR
arlen  out  8  constant BURST_LEN-1
arsize  out  3  constant 3'b100 (16 bytes)
arburst  out  2  constant 2'b01 (INCR)
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  128  read data
rresp  in  2  read response
rlast  in  1  last beat flag
rvalid  in  1  read data valid
rready  out  1  read data ready
busy  out  1  high from start accept until DONE exit
done  out  1  one-cycle pulse at end of check
pass  out  1  result of last check, held until next start
timeout  out  1  last check ended by timeout, held until next start
err_cnt  out  16  mismatched-beat count (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state IDLE; arvalid, rready, busy, done, pass, timeout = 0; beat counter, timer, err_cnt = 0. Reset mid-burst drops arvalid/rready at once; no completion of the in-flight transaction is attempted.
- All control outputs registered; araddr/arlen/arsize/arburst are constants.
- FSM:
  - IDLE: on start=1 -> ADDR. Next cycle: arvalid=1, busy=1. Also clear pass, timeout, err_cnt, internal fail flag.
  - ADDR: hold arvalid and araddr stable until arvalid&arready. On handshake -> DATA: arvalid=0, rready=1 next cycle.
  - DATA: rready held 1. Each rvalid&rready beat:
    - expected = PATTERN + beat_idx, 128-bit add, mod 2^128.
    - Beat fails if rdata != expected or rresp != 2'b00.
    - Beat also fails on rlast mismatch: rlast=0 at beat_idx=BURST_LEN-1, or rlast=1 earlier.
    - Failing beat sets fail flag and increments err_cnt (saturating at 16'hFFFF).
    - Exit to DONE on the beat with beat_idx=BURST_LEN-1 or on rlast=1, whichever is first. rready=0 next cycle.
  - DONE (one cycle): done=1; pass = ~fail & ~timeout; busy=0 next cycle -> IDLE.
- Timeout: timer counts cycles in ADDR/DATA. It resets on entry and on every AR or R handshake. When it reaches TIMEOUT_CYC-1 without a handshake: timeout=1, fail set, -> DONE. Outstanding arvalid/rready dropped.
- Simultaneous handshake and timer expiry in the same cycle: handshake wins, timer resets.
- start while busy or in DONE: ignored, no effect on counters.
- R beats are only accepted in DATA. rready=0 elsewhere, so early rvalid simply stalls.
- BURST_LEN=1: single beat, must carry rlast=1.

Optional Feature:
Macro DDR_RD_CHECK_ERRCNT_EN.
- Defined: err_cnt counts failing beats as above.
- Undefined: err_cnt tied to 16'h0 and its counter logic removed; pass/fail/timeout behaviour unchanged.

Test Plan:
- BURST_LEN=1, start pulse, arready after 3 cycles, one R beat rdata=PATTERN, rresp=0, rlast=1 -> araddr=32'h0000F000, arlen=0, done pulse, pass=1, timeout=0, err_cnt=0.
- BURST_LEN=4, beats PATTERN+0..3 with rvalid gaps of 0/2/5 cycles, rlast on beat 3 -> pass=1. Beat 2 corrupted to PATTERN+7 -> pass=0, err_cnt=1.
- BURST_LEN=1, rresp=2'b10 with correct data -> pass=0, err_cnt=1. Repeat with rlast=0 -> pass=0, done still pulses after that beat.
- TIMEOUT_CYC=16, arready held 0 -> arvalid drops, done pulses 16 cycles after arvalid rises, timeout=1, pass=0. Next start with a good response -> pass=1, timeout=0.
- start pulsed again during DATA -> ignored, single done pulse. rstn asserted mid-DATA -> arvalid/rready/busy/done=0 immediately, FSM in IDLE after release.
- PATTERN=128'hFFFF...FFFF, BURST_LEN=2 -> beat 1 expected 128'h0 (wrap); beat 1 rdata=0 -> pass=1.

Source files
------------

// File: rtl/ddr_ctr_rd_check.sv
// DDR read-back checker: issues one AXI4 INCR read burst at ADDR and checks beat i against PATTERN+i.
// Define DDR_RD_CHECK_ERRCNT_EN to enable the failing-beat counter on err_cnt (tied to zero otherwise).

module ddr_ctr_rd_check #(
   parameter logic [31:0]  ADDR        = 32'h0000_F000,
   parameter int           BURST_LEN   = 1,
   parameter logic [127:0] PATTERN     = 128'h00000000_00000000_12345678_87654321,
   parameter int           TIMEOUT_CYC = 1024
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         start,
   output logic [31:0]  araddr,
   output logic [7:0]   arlen,
   output logic [2:0]   arsize,
   output logic [1:0]   arburst,
   output logic         arvalid,
   input  logic         arready,
   input  logic [127:0] rdata,
   input  logic [1:0]   rresp,
   input  logic         rlast,
   input  logic         rvalid,
   output logic         rready,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic         timeout,
   output logic [15:0]  err_cnt
);

   localparam int            TW        = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]    LAST_IDX  = 8'(BURST_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

   state_t        state;
   logic [7:0]    beat_idx;
   logic [TW-1:0] timer;
   logic          fail;

   logic [127:0]  expected;
   logic          ar_hs;
   logic          r_hs;
   logic          last_beat;
   logic          beat_fail;
   logic          expired;

   assign araddr  = ADDR;
   assign arlen   = LAST_IDX;
   assign arsize  = 3'b100;
   assign arburst = 2'b01;

   // A beat is bad on wrong data, non-OKAY response, or rlast not matching the final index.
   assign expected  = PATTERN + {120'd0, beat_idx};
   assign ar_hs     = arvalid & arready;
   assign r_hs      = rvalid & rready;
   assign last_beat = (beat_idx == LAST_IDX);
   assign beat_fail = (rdata != expected) | (rresp != 2'b00) | (rlast != last_beat);
   assign expired   = (timer == TIMER_MAX);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= S_IDLE;
         arvalid  <= 1'b0;
         rready   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         timeout  <= 1'b0;
         fail     <= 1'b0;
         beat_idx <= 8'd0;
         timer    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_ADDR;
                  arvalid  <= 1'b1;
                  busy     <= 1'b1;
                  pass     <= 1'b0;
                  timeout  <= 1'b0;
                  fail     <= 1'b0;
                  beat_idx <= 8'd0;
                  timer    <= '0;
               end
            end
            S_ADDR: begin
               if (ar_hs) begin
                  state   <= S_DATA;
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  timer   <= '0;
               end else if (expired) begin
                  state   <= S_DONE;
                  arvalid <= 1'b0;
                  timeout <= 1'b1;
                  fail    <= 1'b1;
                  pass    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_DATA: begin
               // A handshake always beats a coinciding timer expiry.
               if (r_hs) begin
                  timer <= '0;
                  if (beat_fail) fail <= 1'b1;
                  if (last_beat | rlast) begin
                     state  <= S_DONE;
                     rready <= 1'b0;
                     done   <= 1'b1;
                     pass   <= ~(fail | beat_fail);
                  end else begin
                     beat_idx <= beat_idx + 8'd1;
                  end
               end else if (expired) begin
                  state   <= S_DONE;
                  rready  <= 1'b0;
                  timeout <= 1'b1;
                  fail    <= 1'b1;
                  pass    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DDR_RD_CHECK_ERRCNT_EN
   logic [15:0] err_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_q <= 16'h0;
      end else if (state == S_IDLE && start) begin
         err_q <= 16'h0;
      end else if (state == S_DATA && r_hs && beat_fail && err_q != 16'hFFFF) begin
         err_q <= err_q + 16'h1;
      end
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_ddr_ctr_rd_check.sv
// Testbench for ddr_ctr_rd_check: table vectors, hand-written corner sequences and random bursts
// checked against a transaction-level model of the read-back rules.

module tb_ddr_ctr_rd_check;

   localparam int           BL  = 4;
   localparam int           TO  = 16;
   localparam logic [127:0] PAT = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE;

   logic         clk;
   logic         rstn;
   logic         start;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arvalid;
   logic         arready;
   logic [127:0] rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;
   logic         busy;
   logic         done;
   logic         pass;
   logic         timeout;
   logic [15:0]  err_cnt;

   int tests_run    = 0;
   int tests_failed = 0;
   int done_pulses  = 0;

   typedef struct {
      int               ar_delay;
      bit               ar_never;
      int               nsent;
      bit               restart;
      logic [3:0][2:0]  gap;
      logic [3:0][127:0] data;
      logic [3:0][1:0]  resp;
      logic [3:0]       last;
      bit               exp_pass;
      bit               exp_timeout;
      int               exp_err;
   } txn_t;

   txn_t vec[9];

   ddr_ctr_rd_check #(
      .ADDR(32'h0000_F000),
      .BURST_LEN(BL),
      .PATTERN(PAT),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_pulses++;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input string what,
                              input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s %s: got %0h expected %0h", tag, what, got, exp);
      end
   endtask

   function automatic txn_t goodTxn();
      txn_t t;
      t.ar_delay = 1;
      t.ar_never = 1'b0;
      t.nsent    = BL;
      t.restart  = 1'b0;
      t.gap      = '0;
      for (int i = 0; i < BL; i++) begin
         t.data[i] = PAT + 128'(i);
         t.resp[i] = 2'b00;
      end
      t.last        = 4'b1000;
      t.exp_pass    = 1'b1;
      t.exp_timeout = 1'b0;
      t.exp_err     = 0;
      return t;
   endfunction

   // Burst outcome from the rules: stop at first rlast or beat BL-1; too few beats means timeout.
   function automatic void modelTxn(input txn_t t, output bit p, output bit to,
                                    output int e, output int n);
      int consumed = BL;
      for (int i = 0; i < BL; i++) begin
         if (t.last[i]) begin
            consumed = i + 1;
            break;
         end
      end
      to = t.ar_never || (t.nsent < consumed);
      n  = t.ar_never ? 0 : ((t.nsent < consumed) ? t.nsent : consumed);
      e  = 0;
      for (int i = 0; i < n; i++) begin
         if (t.data[i] != PAT + 128'(i) || t.resp[i] != 2'b00 || t.last[i] != (i == BL - 1))
            e++;
      end
      p = !to && (e == 0);
   endfunction

   task automatic sendBeat(input string tag, input logic [127:0] d, input logic [1:0] r,
                           input logic l, input int gap);
      int w = 0;
      rvalid = 1'b0;
      repeat (gap) @(negedge clk);
      rdata  = d;
      rresp  = r;
      rlast  = l;
      rvalid = 1'b1;
      while (rready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      checkOutput(tag, "rready", 32'(rready), 32'd1);
      @(negedge clk);
      rvalid = 1'b0;
      rlast  = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      int k = 0;
      while (done !== 1'b1 && k < 60) begin
         @(negedge clk);
         k++;
      end
      checkOutput(tag, "done_seen", 32'(done), 32'd1);
   endtask

   task automatic applyStimulus(input txn_t t, input string tag);
      bit p, to;
      int e, n, base, exp_err;
      modelTxn(t, p, to, e, n);
      base = done_pulses;
`ifdef DDR_RD_CHECK_ERRCNT_EN
      exp_err = t.exp_err;
`else
      exp_err = 0;
`endif
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput(tag, "arvalid_busy", 32'({arvalid, busy}), 32'd3);
      if (!t.ar_never) begin
         repeat (t.ar_delay) @(negedge clk);
         arready = 1'b1;
         @(negedge clk);
         arready = 1'b0;
         for (int k = 0; k < n; k++) begin
            if (k == 1 && t.restart) begin
               start = 1'b1;
               @(negedge clk);
               start = 1'b0;
            end
            sendBeat(tag, t.data[k], t.resp[k], t.last[k], int'(t.gap[k]));
         end
      end
      waitDone(tag);
      @(negedge clk);
      checkOutput(tag, "pass", 32'(pass), 32'(t.exp_pass));
      checkOutput(tag, "timeout", 32'(timeout), 32'(t.exp_timeout));
      checkOutput(tag, "err_cnt", 32'(err_cnt), 32'(exp_err));
      checkOutput(tag, "busy_after", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput(tag, "done_pulses", 32'(done_pulses - base), 32'd1);
      checkOutput(tag, "idle_arvalid", 32'(arvalid), 32'd0);
   endtask

   initial begin
      txn_t t;
      bit   p, to;
      int   e, n, k;

      for (int i = 0; i < 9; i++) vec[i] = goodTxn();
      vec[0].ar_delay = 3;
      vec[0].gap[1] = 3'd0; vec[0].gap[2] = 3'd2; vec[0].gap[3] = 3'd5;
      vec[1].data[2] = PAT + 128'd7;
      vec[1].exp_pass = 1'b0; vec[1].exp_err = 1;
      vec[2].resp[0] = 2'b10;
      vec[2].exp_pass = 1'b0; vec[2].exp_err = 1;
      vec[3].last = 4'b0000;
      vec[3].exp_pass = 1'b0; vec[3].exp_err = 1;
      vec[4].last = 4'b0010;
      vec[4].exp_pass = 1'b0; vec[4].exp_err = 1;
      vec[5].nsent = 2;
      vec[5].exp_pass = 1'b0; vec[5].exp_timeout = 1'b1;
      vec[6].ar_never = 1'b1;
      vec[6].exp_pass = 1'b0; vec[6].exp_timeout = 1'b1;
      vec[7].restart = 1'b1;
      vec[8].data[0] = PAT ^ 128'd1; vec[8].resp[1] = 2'b11; vec[8].data[3] = 128'd0;
      vec[8].exp_pass = 1'b0; vec[8].exp_err = 3;

      rstn = 1'b0; start = 1'b0; arready = 1'b0;
      rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset", "ctrl", 32'({arvalid, rready, busy, done, pass, timeout}), 32'd0);
      checkOutput("reset", "err_cnt", 32'(err_cnt), 32'd0);
      checkOutput("reset", "araddr", araddr, 32'h0000_F000);
      checkOutput("reset", "arlen", 32'(arlen), 32'd3);
      checkOutput("reset", "arsize_burst", 32'({arsize, arburst}), 32'b100_01);
      rstn = 1'b1;
      @(negedge clk);
      checkOutput("idle", "ctrl", 32'({arvalid, rready, busy, done}), 32'd0);

      for (int i = 0; i < 9; i++) applyStimulus(vec[i], $sformatf("vec%0d", i));

      // AR never accepted: done must rise TO cycles after arvalid.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("to_seq", "arvalid_rise", 32'(arvalid), 32'd1);
      k = 0;
      while (done !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      checkOutput("to_seq", "latency", 32'(k), 32'(TO));
      checkOutput("to_seq", "arvalid_drop", 32'(arvalid), 32'd0);
      @(negedge clk);
      checkOutput("to_seq", "timeout_pass", 32'({timeout, pass}), 32'b10);
      repeat (2) @(negedge clk);
      applyStimulus(vec[0], "after_to");

      // Reset in the middle of the data phase.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      checkOutput("rst_seq", "rready_in_data", 32'(rready), 32'd1);
      #2 rstn = 1'b0;
      #1 checkOutput("rst_seq", "async_clear", 32'({arvalid, rready, busy, done}), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checkOutput("rst_seq", "idle_after", 32'({arvalid, rready, busy, done}), 32'd0);
      applyStimulus(vec[0], "after_rst");

      for (int r = 0; r < 40; r++) begin
         t = goodTxn();
         t.ar_delay = int'($urandom_range(0, 8));
         t.ar_never = ($urandom_range(0, 24) == 0);
         for (int i = 0; i < BL; i++) begin
            t.gap[i] = 3'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) t.data[i] = t.data[i] ^ (128'd1 << $urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) t.resp[i] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) t.last[i] = ~t.last[i];
         end
         if ($urandom_range(0, 9) == 0) t.nsent = int'($urandom_range(0, 3));
         modelTxn(t, p, to, e, n);
         t.exp_pass    = p;
         t.exp_timeout = to;
         t.exp_err     = e;
         applyStimulus(t, $sformatf("rnd%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
